// File: rtl/backoff_ctrl_multi_ac.sv
// Multi-AC EDCA backoff engine: one FSM and one slot down-counter per access category,
// with internal collision resolution where the highest-index AC in DONE wins.
module backoff_ctrl_multi_ac #(
  parameter int NUM_AC    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        macCoreClk,
  input  logic                        macCoreClkHardRst_n,
  input  logic                        macCoreClkSoftRst_n,
  input  logic [NUM_AC-1:0]           backoffEnable,
  input  logic [NUM_AC-1:0]           acHasData,
  input  logic [NUM_AC*CNT_WIDTH-1:0] backoffLoadVal,
  input  logic [NUM_AC-1:0]           aifsFlag,
  input  logic                        macPhyIfRxCca,
  input  logic                        channelBusy,
  input  logic                        txInProgress,
  input  logic                        tickSlot_p,
  input  logic                        txDone_p,
  output logic [NUM_AC*CNT_WIDTH-1:0] backoffCnt,
  output logic [NUM_AC-1:0]           backoffDone,
  output logic [NUM_AC-1:0]           acGrant,
  output logic [NUM_AC-1:0]           internalCollision_p,
  output logic [NUM_AC-1:0]           acProtTriggerFlagReset,
  output logic [NUM_AC*3-1:0]         backoffCtrlCs
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DEC  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  logic              busy;
  logic              medium_busy;
  logic              tx_fall;
  logic              tx_in_progress_reg;
  logic              grant_found;
  logic [NUM_AC-1:0] ac_lose;

  assign medium_busy = macPhyIfRxCca | channelBusy;
  assign busy        = medium_busy | txInProgress;
  assign tx_fall     = tx_in_progress_reg & ~txInProgress;

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      tx_in_progress_reg <= 1'b0;
    end else if (!macCoreClkSoftRst_n) begin
      tx_in_progress_reg <= 1'b0;
    end else begin
      tx_in_progress_reg <= txInProgress;
    end
  end

  // Fixed priority: scan from the top index down, first DONE found wins.
  always_comb begin
    acGrant     = '0;
    grant_found = 1'b0;
    for (int i = NUM_AC - 1; i >= 0; i--) begin
      if (backoffDone[i] && !grant_found) begin
        acGrant[i]  = 1'b1;
        grant_found = 1'b1;
      end
    end
  end

  // Any DONE AC that is not granted has a higher-index AC also in DONE.
  assign ac_lose = backoffDone & ~acGrant;

  generate
    for (genvar gi = 0; gi < NUM_AC; gi++) begin : g_ac
      state_t               state_reg;
      state_t               state_next;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic [CNT_WIDTH-1:0] load_val;
      logic                 prot_reg;
      logic                 coll_reg;

      assign load_val = backoffLoadVal[gi*CNT_WIDTH +: CNT_WIDTH];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          ST_IDLE: state_next = ST_LD;
          ST_LD: begin
            cnt_next   = load_val;
            state_next = ST_CHK;
          end
          ST_CHK: begin
            if (!busy && acHasData[gi]) state_next = ST_WAIT;
          end
          ST_WAIT: begin
            if (busy)              state_next = ST_CHK;
            else if (aifsFlag[gi]) state_next = ST_DEC;
          end
          ST_DEC: begin
            if (busy) begin
              state_next = ST_CHK;
            end else if (tickSlot_p) begin
              if (cnt_reg == '0) state_next = ST_DONE;
              else               cnt_next   = cnt_reg - CNT_WIDTH'(1);
            end
          end
          ST_DONE: begin
            if (ac_lose[gi])                                    state_next = ST_LD;
            else if ((medium_busy && !txInProgress) || txDone_p) state_next = ST_LD;
            else if (tx_fall)                                   state_next = ST_WAIT;
          end
          default: state_next = ST_IDLE;
        endcase
        // A disabled AC parks in IDLE and keeps its count until the next load.
        if (!backoffEnable[gi]) begin
          state_next = ST_IDLE;
          cnt_next   = cnt_reg;
        end
      end

      always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
        if (!macCoreClkHardRst_n) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          prot_reg  <= 1'b0;
          coll_reg  <= 1'b0;
        end else if (!macCoreClkSoftRst_n) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          prot_reg  <= 1'b0;
          coll_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          prot_reg  <= (state_reg == ST_LD);
          coll_reg  <= ac_lose[gi];
        end
      end

      assign backoffCtrlCs[gi*3 +: 3]                = state_reg;
      assign backoffCnt[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_reg;
      assign backoffDone[gi]                         = (state_reg == ST_DONE);
      assign acProtTriggerFlagReset[gi]              = prot_reg;
      assign internalCollision_p[gi]                 = coll_reg;
    end
  endgenerate

endmodule

// File: tb/tb_backoff_ctrl_multi_ac.sv
// Bench for backoff_ctrl_multi_ac: per-cycle vector table plus hand-built corner sequences,
// expectations queued on drive and compared one cycle later.
module tb_backoff_ctrl_multi_ac;

  localparam int NUM_AC = 4;
  localparam int CW     = 16;

  localparam int F_CCA  = 16;
  localparam int F_NAV  = 8;
  localparam int F_TXIP = 4;
  localparam int F_TICK = 2;
  localparam int F_DONE = 1;

  typedef struct {
    string       name;
    logic [3:0]  en, dat, aif;
    logic        cca, nav, txip, tick, txdone, srst_n;
    logic [63:0] load;
    logic [11:0] cs;
    logic [63:0] cnt;
    logic [3:0]  grant, coll, prot;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 hard_rst_n = 1'b0;
  logic                 soft_rst_n = 1'b1;
  logic [NUM_AC-1:0]    en = '0, has_data = '0, aifs = '0;
  logic [NUM_AC*CW-1:0] load_val = '0;
  logic                 cca = 1'b0, nav = 1'b0, txip = 1'b0, tick = 1'b0, txdone = 1'b0;
  logic [NUM_AC*CW-1:0] cnt_o;
  logic [NUM_AC-1:0]    done_o, grant_o, coll_o, prot_o;
  logic [NUM_AC*3-1:0]  cs_o;

  int   n_vec = 0;
  int   n_miss = 0;
  vec_t sb_q[$];
  vec_t tbl[22];

  int          s_en, s_data, s_aifs, s_flags, s_srst;
  logic [63:0] s_load;

  always #5 clk = ~clk;

  backoff_ctrl_multi_ac #(.NUM_AC(NUM_AC), .CNT_WIDTH(CW)) dut (
    .macCoreClk            (clk),
    .macCoreClkHardRst_n   (hard_rst_n),
    .macCoreClkSoftRst_n   (soft_rst_n),
    .backoffEnable         (en),
    .acHasData             (has_data),
    .backoffLoadVal        (load_val),
    .aifsFlag              (aifs),
    .macPhyIfRxCca         (cca),
    .channelBusy           (nav),
    .txInProgress          (txip),
    .tickSlot_p            (tick),
    .txDone_p              (txdone),
    .backoffCnt            (cnt_o),
    .backoffDone           (done_o),
    .acGrant               (grant_o),
    .internalCollision_p   (coll_o),
    .acProtTriggerFlagReset(prot_o),
    .backoffCtrlCs         (cs_o)
  );

  function automatic logic [11:0] cs4(int s3, int s2, int s1, int s0);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  function automatic logic [63:0] c4(int c3, int c2, int c1, int c0);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic vec_t mk(string nm, int e, int d, int a, int flags, int srst,
                              logic [63:0] ld, logic [11:0] cs, logic [63:0] cnt,
                              int grant, int coll, int prot);
    vec_t v;
    v.name = nm;  v.en = 4'(e);  v.dat = 4'(d);  v.aif = 4'(a);
    v.cca = flags[4];  v.nav = flags[3];  v.txip = flags[2];
    v.tick = flags[1]; v.txdone = flags[0]; v.srst_n = srst[0];
    v.load = ld;  v.cs = cs;  v.cnt = cnt;
    v.grant = 4'(grant);  v.coll = 4'(coll);  v.prot = 4'(prot);
    return v;
  endfunction

  task automatic check(input vec_t e);
    logic [3:0] exp_done;
    for (int i = 0; i < NUM_AC; i++) exp_done[i] = (e.cs[i*3 +: 3] == 3'd5);
    n_vec++;
    if (cs_o !== e.cs) begin
      n_miss++; $display("FAIL %s state: got %h want %h", e.name, cs_o, e.cs);
    end
    if (cnt_o !== e.cnt) begin
      n_miss++; $display("FAIL %s cnt: got %h want %h", e.name, cnt_o, e.cnt);
    end
    if (grant_o !== e.grant) begin
      n_miss++; $display("FAIL %s grant: got %b want %b", e.name, grant_o, e.grant);
    end
    if (coll_o !== e.coll) begin
      n_miss++; $display("FAIL %s collision: got %b want %b", e.name, coll_o, e.coll);
    end
    if (prot_o !== e.prot) begin
      n_miss++; $display("FAIL %s prot_reset: got %b want %b", e.name, prot_o, e.prot);
    end
    if (done_o !== exp_done) begin
      n_miss++; $display("FAIL %s done: got %b want %b", e.name, done_o, exp_done);
    end
    $display("vec %0d %s: cs=%h cnt=%h grant=%b coll=%b prot=%b",
             n_vec, e.name, cs_o, cnt_o, grant_o, coll_o, prot_o);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    en = v.en;  has_data = v.dat;  aifs = v.aif;  load_val = v.load;
    cca = v.cca;  nav = v.nav;  txip = v.txip;  tick = v.tick;  txdone = v.txdone;
    soft_rst_n = v.srst_n;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e);
  endtask

  task automatic step(string nm, logic [11:0] cs, logic [63:0] cnt, int grant, int coll, int prot);
    apply(mk(nm, s_en, s_data, s_aifs, s_flags, s_srst, s_load, cs, cnt, grant, coll, prot));
    s_flags = s_flags & ~(F_TICK | F_DONE);
  endtask

  task automatic check_now(input vec_t v);
    vec_t e;
    sb_q.push_back(v);
    e = sb_q.pop_front();
    check(e);
  endtask

  initial begin
    // AC1 load 3 walk to DONE and grant; then AC0/AC3 load 0 collision
    tbl[0]  = mk("s1_ld",      2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,1,0), c4(0,0,0,0), 0, 0, 0);
    tbl[1]  = mk("s1_chk",     2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,2,0), c4(0,0,3,0), 0, 0, 2);
    tbl[2]  = mk("s1_wait",    2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,3,0), c4(0,0,3,0), 0, 0, 0);
    tbl[3]  = mk("s1_dec",     2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,4,0), c4(0,0,3,0), 0, 0, 0);
    tbl[4]  = mk("s1_tick1",   2, 2, 2, F_TICK, 1, c4(0,0,3,0), cs4(0,0,4,0), c4(0,0,2,0), 0, 0, 0);
    tbl[5]  = mk("s1_tick2",   2, 2, 2, F_TICK, 1, c4(0,0,3,0), cs4(0,0,4,0), c4(0,0,1,0), 0, 0, 0);
    tbl[6]  = mk("s1_notick",  2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,4,0), c4(0,0,1,0), 0, 0, 0);
    tbl[7]  = mk("s1_tick3",   2, 2, 2, F_TICK, 1, c4(0,0,3,0), cs4(0,0,4,0), c4(0,0,0,0), 0, 0, 0);
    tbl[8]  = mk("s1_tick4",   2, 2, 2, F_TICK, 1, c4(0,0,3,0), cs4(0,0,5,0), c4(0,0,0,0), 2, 0, 0);
    tbl[9]  = mk("s1_hold",    2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,5,0), c4(0,0,0,0), 2, 0, 0);
    tbl[10] = mk("s1_cca_rld", 2, 2, 2, F_CCA,  1, c4(0,0,3,0), cs4(0,0,1,0), c4(0,0,0,0), 0, 0, 0);
    tbl[11] = mk("s1_rld_chk", 2, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,2,0), c4(0,0,3,0), 0, 0, 2);
    tbl[12] = mk("s1_disable", 0, 2, 2, 0,      1, c4(0,0,3,0), cs4(0,0,0,0), c4(0,0,3,0), 0, 0, 0);
    tbl[13] = mk("s3_srst",    0, 0, 0, 0,      0, c4(0,0,0,0), cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    tbl[14] = mk("s3_ld",      9, 9, 9, 0,      1, c4(0,0,0,0), cs4(1,0,0,1), c4(0,0,0,0), 0, 0, 0);
    tbl[15] = mk("s3_chk",     9, 9, 9, 0,      1, c4(0,0,0,0), cs4(2,0,0,2), c4(0,0,0,0), 0, 0, 9);
    tbl[16] = mk("s3_wait",    9, 9, 9, 0,      1, c4(0,0,0,0), cs4(3,0,0,3), c4(0,0,0,0), 0, 0, 0);
    tbl[17] = mk("s3_dec",     9, 9, 9, 0,      1, c4(0,0,0,0), cs4(4,0,0,4), c4(0,0,0,0), 0, 0, 0);
    tbl[18] = mk("s3_done",    9, 9, 9, F_TICK, 1, c4(0,0,0,0), cs4(5,0,0,5), c4(0,0,0,0), 8, 0, 0);
    tbl[19] = mk("s3_collide", 9, 9, 9, 0,      1, c4(0,0,0,0), cs4(5,0,0,1), c4(0,0,0,0), 8, 1, 0);
    tbl[20] = mk("s3_reload",  9, 9, 9, 0,      1, c4(0,0,0,0), cs4(5,0,0,2), c4(0,0,0,0), 8, 0, 1);
    tbl[21] = mk("s3_rewait",  9, 9, 9, 0,      1, c4(0,0,0,0), cs4(5,0,0,3), c4(0,0,0,0), 8, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check_now(mk("hard_rst", 0, 0, 0, 0, 1, '0, '0, '0, 0, 0, 0));
    hard_rst_n = 1'b1;

    for (int k = 0; k < 22; k++) apply(tbl[k]);

    // AC1: busy interrupts DEC, count is held, resumes after AIFS
    s_en = 2; s_data = 2; s_aifs = 2; s_flags = 0; s_srst = 0; s_load = c4(0,0,2,0);
    step("s2_srst", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    s_srst = 1;
    step("s2_ld",   cs4(0,0,1,0), c4(0,0,0,0), 0, 0, 0);
    step("s2_chk",  cs4(0,0,2,0), c4(0,0,2,0), 0, 0, 2);
    step("s2_wait", cs4(0,0,3,0), c4(0,0,2,0), 0, 0, 0);
    step("s2_dec",  cs4(0,0,4,0), c4(0,0,2,0), 0, 0, 0);
    s_flags = F_CCA | F_TICK;
    step("s2_busy", cs4(0,0,2,0), c4(0,0,2,0), 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      s_flags = F_CCA;
      step("s2_busy_hold", cs4(0,0,2,0), c4(0,0,2,0), 0, 0, 0);
    end
    s_flags = 0; s_aifs = 0;
    step("s2_rewait", cs4(0,0,3,0), c4(0,0,2,0), 0, 0, 0);
    step("s2_noaifs", cs4(0,0,3,0), c4(0,0,2,0), 0, 0, 0);
    s_aifs = 2;
    step("s2_redec",  cs4(0,0,4,0), c4(0,0,2,0), 0, 0, 0);
    s_flags = F_TICK; step("s2_t1", cs4(0,0,4,0), c4(0,0,1,0), 0, 0, 0);
    s_flags = F_TICK; step("s2_t2", cs4(0,0,4,0), c4(0,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s2_t3", cs4(0,0,5,0), c4(0,0,0,0), 2, 0, 0);

    // AC2: tx falling edge returns DONE to WAIT; txDone beats falling edge
    s_en = 4; s_data = 4; s_aifs = 4; s_flags = 0; s_srst = 0; s_load = c4(0,1,0,0);
    step("s4_srst", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    s_srst = 1;
    step("s4_ld",   cs4(0,1,0,0), c4(0,0,0,0), 0, 0, 0);
    step("s4_chk",  cs4(0,2,0,0), c4(0,1,0,0), 0, 0, 4);
    step("s4_wait", cs4(0,3,0,0), c4(0,1,0,0), 0, 0, 0);
    step("s4_dec",  cs4(0,4,0,0), c4(0,1,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s4_t1",   cs4(0,4,0,0), c4(0,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s4_done", cs4(0,5,0,0), c4(0,0,0,0), 4, 0, 0);
    s_flags = F_TXIP; step("s4_txip_a", cs4(0,5,0,0), c4(0,0,0,0), 4, 0, 0);
    step("s4_txip_b", cs4(0,5,0,0), c4(0,0,0,0), 4, 0, 0);
    s_flags = 0;
    step("s4_txfall", cs4(0,3,0,0), c4(0,0,0,0), 0, 0, 0);
    step("s4_redec",  cs4(0,4,0,0), c4(0,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s4_done2", cs4(0,5,0,0), c4(0,0,0,0), 4, 0, 0);
    s_flags = F_TXIP; step("s4_txip_c", cs4(0,5,0,0), c4(0,0,0,0), 4, 0, 0);
    s_flags = F_DONE; step("s4_txdone", cs4(0,1,0,0), c4(0,0,0,0), 0, 0, 0);
    step("s4_prot",     cs4(0,2,0,0), c4(0,1,0,0), 0, 0, 4);
    step("s4_prot_off", cs4(0,3,0,0), c4(0,1,0,0), 0, 0, 0);

    // AC3: enable dropped mid-count, then re-enabled with a new load
    s_en = 8; s_data = 8; s_aifs = 8; s_flags = 0; s_srst = 0; s_load = c4(5,0,0,0);
    step("s5_srst", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    s_srst = 1;
    step("s5_ld",   cs4(1,0,0,0), c4(0,0,0,0), 0, 0, 0);
    step("s5_chk",  cs4(2,0,0,0), c4(5,0,0,0), 0, 0, 8);
    step("s5_wait", cs4(3,0,0,0), c4(5,0,0,0), 0, 0, 0);
    step("s5_dec",  cs4(4,0,0,0), c4(5,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s5_t1", cs4(4,0,0,0), c4(4,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s5_t2", cs4(4,0,0,0), c4(3,0,0,0), 0, 0, 0);
    s_en = 0;
    step("s5_disable", cs4(0,0,0,0), c4(3,0,0,0), 0, 0, 0);
    s_flags = F_TICK; step("s5_idle_tick", cs4(0,0,0,0), c4(3,0,0,0), 0, 0, 0);
    s_en = 8; s_load = c4(7,0,0,0);
    step("s5_reld",  cs4(1,0,0,0), c4(3,0,0,0), 0, 0, 0);
    step("s5_newld", cs4(2,0,0,0), c4(7,0,0,0), 0, 0, 8);

    // All ACs counting, soft reset mid-count
    s_en = 15; s_data = 15; s_aifs = 15; s_flags = 0; s_srst = 0; s_load = c4(13,12,11,10);
    step("s6_srst0", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    s_srst = 1;
    step("s6_ld",   cs4(1,1,1,1), c4(0,0,0,0), 0, 0, 0);
    step("s6_chk",  cs4(2,2,2,2), c4(13,12,11,10), 0, 0, 15);
    step("s6_wait", cs4(3,3,3,3), c4(13,12,11,10), 0, 0, 0);
    step("s6_dec",  cs4(4,4,4,4), c4(13,12,11,10), 0, 0, 0);
    s_flags = F_TICK; step("s6_t1", cs4(4,4,4,4), c4(12,11,10,9), 0, 0, 0);
    s_flags = F_TICK; s_srst = 0;
    step("s6_srst", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);
    s_srst = 1; s_en = 0;
    step("s6_after", cs4(0,0,0,0), c4(0,0,0,0), 0, 0, 0);

    // Asynchronous hard reset between clock edges
    s_en = 15;
    step("hr_ld",  cs4(1,1,1,1), c4(0,0,0,0), 0, 0, 0);
    step("hr_chk", cs4(2,2,2,2), c4(13,12,11,10), 0, 0, 15);
    #2;
    hard_rst_n = 1'b0;
    #1;
    check_now(mk("hard_rst_mid", 15, 15, 15, 0, 1, c4(13,12,11,10), '0, '0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
